// File: rtl/dfp96_digit_normalizer.sv
// Four-stage BCD normaliser between the DFP96 add/sub core and the rounder.
// Folds the carry digit or strips leading zero digits, clamping the shift by the exponent.
module dfp96_digit_normalizer #(
   parameter logic [11:0] EXP_MAX = 12'd3071,
   parameter logic [11:0] EXP_INF = 12'hFFF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   input  logic         i_valid,
   input  logic         under_i,
   input  logic         i_sign,
   input  logic [11:0]  i_exp,
   input  logic [207:0] i_sig,
   input  logic [3:0]   i_flags,
   output logic         o_valid,
   output logic         o_sign,
   output logic [11:0]  o_exp,
   output logic [99:0]  o_sig,
   output logic [7:0]   o_gr,
   output logic         o_sticky,
   output logic         o_zero,
   output logic         o_under,
   output logic         o_over,
   output logic [3:0]   o_flags
);

   logic         p1_v, p1_under, p1_sign;
   logic [11:0]  p1_exp;
   logic [207:0] p1_sig;
   logic [3:0]   p1_flags;
   logic [51:0]  p1_nz, nz_c;

   logic         p2_v, p2_under, p2_sign, p2_carry, p2_allz;
   logic [11:0]  p2_exp;
   logic [207:0] p2_sig;
   logic [3:0]   p2_flags;
   logic [5:0]   p2_lzc, lzc_c;

   logic         p3_v, p3_sign, p3_clr, p3_zero, p3_under, p3_over;
   logic [11:0]  p3_exp;
   logic [207:0] p3_sig;
   logic [3:0]   p3_flags;
   logic [5:0]   p3_k;

   logic         clr_c, zero_c, under_c, over_c;
   logic [11:0]  exp_c;
   logic [3:0]   flags_c;
   logic [5:0]   k_c, s_c;
   logic [207:0] win_c;

   always_comb begin
      for (int k = 0; k < 52; k++) nz_c[k] = |i_sig[4*k +: 4];
   end

   always_comb begin
      logic found;
      found = 1'b0;
      lzc_c = 6'd51;
      for (int k = 50; k >= 0; k--) begin
         if (!found && p1_nz[k]) begin
            lzc_c = 6'(50 - k);
            found = 1'b1;
         end
      end
   end

   // k is the left shift applied to the raw 52-digit vector so that the window top lands on digit 51:
   // k=0 keeps the carry digit on top, k=s+1 selects digit 50-s.
   always_comb begin
      k_c     = 6'd1;
      s_c     = 6'd0;
      exp_c   = p2_exp;
      clr_c   = 1'b0;
      zero_c  = 1'b0;
      under_c = p2_under;
      over_c  = 1'b0;
      flags_c = p2_flags;
      if (|p2_flags) begin
         k_c = 6'd1;
      end else if (p2_carry) begin
         if (p2_exp == EXP_MAX) begin
            over_c     = 1'b1;
            exp_c      = EXP_INF;
            clr_c      = 1'b1;
            flags_c[0] = 1'b1;
         end else begin
            k_c   = 6'd0;
            exp_c = p2_exp + 12'd1;
         end
      end else if (p2_allz) begin
         exp_c  = 12'd0;
         zero_c = 1'b1;
         clr_c  = 1'b1;
      end else begin
         s_c   = ({6'd0, p2_lzc} < p2_exp) ? p2_lzc : p2_exp[5:0];
         k_c   = s_c + 6'd1;
         exp_c = p2_exp - {6'd0, s_c};
         if (s_c < p2_lzc) under_c = 1'b1;
      end
   end

   assign win_c = p3_sig << {p3_k, 2'b00};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p1_v <= 1'b0; p1_under <= 1'b0; p1_sign <= 1'b0; p1_exp <= '0;
         p1_sig <= '0; p1_flags <= '0; p1_nz <= '0;
         p2_v <= 1'b0; p2_under <= 1'b0; p2_sign <= 1'b0; p2_carry <= 1'b0;
         p2_allz <= 1'b0; p2_exp <= '0; p2_sig <= '0; p2_flags <= '0; p2_lzc <= '0;
         p3_v <= 1'b0; p3_sign <= 1'b0; p3_clr <= 1'b0; p3_zero <= 1'b0;
         p3_under <= 1'b0; p3_over <= 1'b0; p3_exp <= '0; p3_sig <= '0;
         p3_flags <= '0; p3_k <= '0;
         o_valid <= 1'b0; o_sign <= 1'b0; o_exp <= '0; o_sig <= '0; o_gr <= '0;
         o_sticky <= 1'b0; o_zero <= 1'b0; o_under <= 1'b0; o_over <= 1'b0; o_flags <= '0;
      end else if (ce) begin
         p1_v <= i_valid; p1_under <= under_i; p1_sign <= i_sign; p1_exp <= i_exp;
         p1_sig <= i_sig; p1_flags <= i_flags; p1_nz <= nz_c;

         p2_v <= p1_v; p2_under <= p1_under; p2_sign <= p1_sign; p2_exp <= p1_exp;
         p2_sig <= p1_sig; p2_flags <= p1_flags;
         p2_carry <= p1_nz[51]; p2_allz <= ~|p1_nz; p2_lzc <= lzc_c;

         p3_v <= p2_v; p3_sign <= p2_sign; p3_sig <= p2_sig; p3_k <= k_c;
         p3_exp <= exp_c; p3_clr <= clr_c; p3_zero <= zero_c; p3_under <= under_c;
         p3_over <= over_c; p3_flags <= flags_c;

         o_valid  <= p3_v;
         o_sign   <= p3_sign;
         o_exp    <= p3_exp;
         o_sig    <= p3_clr ? '0 : win_c[207:108];
         o_gr     <= p3_clr ? '0 : win_c[107:100];
         o_sticky <= p3_clr ? 1'b0 : |win_c[99:0];
         o_zero   <= p3_zero;
         o_under  <= p3_under;
         o_over   <= p3_over;
         o_flags  <= p3_flags;
      end
   end

endmodule

// File: tb/tb_dfp96_digit_normalizer.sv
// Scoreboard bench for dfp96_digit_normalizer: a digit-indexed model predicts each beat,
// a negedge monitor pops and compares whenever an output register updated with valid data.
module tb_dfp96_digit_normalizer;

   typedef struct packed {
      logic        sign;
      logic [11:0] exp;
      logic [99:0] sig;
      logic [7:0]  gr;
      logic        sticky;
      logic        zero;
      logic        under;
      logic        over;
      logic [3:0]  flags;
   } res_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ce = 1'b1;
   logic         i_valid = 1'b0, under_i = 1'b0, i_sign = 1'b0;
   logic [11:0]  i_exp = '0;
   logic [207:0] i_sig = '0;
   logic [3:0]   i_flags = '0;
   logic         o_valid, o_sign, o_sticky, o_zero, o_under, o_over;
   logic [11:0]  o_exp;
   logic [99:0]  o_sig;
   logic [7:0]   o_gr;
   logic [3:0]   o_flags;

   int   n_pass = 0, n_total = 0;
   res_t q[$];
   logic ce_at_edge = 1'b0;

   dfp96_digit_normalizer dut (
      .clk(clk), .rst(rst), .ce(ce), .i_valid(i_valid), .under_i(under_i),
      .i_sign(i_sign), .i_exp(i_exp), .i_sig(i_sig), .i_flags(i_flags),
      .o_valid(o_valid), .o_sign(o_sign), .o_exp(o_exp), .o_sig(o_sig), .o_gr(o_gr),
      .o_sticky(o_sticky), .o_zero(o_zero), .o_under(o_under), .o_over(o_over),
      .o_flags(o_flags)
   );

   always #5 clk = ~clk;

   function automatic res_t model(input logic sign, input logic [11:0] exp,
                                  input logic [207:0] sig, input logic [3:0] flags,
                                  input logic under);
      res_t r;
      logic [3:0] d[52];
      int top, h, lz, s, idx;
      logic clr;
      for (int i = 0; i < 52; i++) d[i] = sig[4*i +: 4];
      r = '0;
      r.sign  = sign;
      r.flags = flags;
      r.under = under;
      r.exp   = exp;
      clr = 1'b0;
      top = 50;
      if (flags != 4'd0) begin
         top = 50;
      end else if (d[51] != 4'd0) begin
         if (exp == 12'd3071) begin
            r.over = 1'b1; r.exp = 12'hFFF; r.flags[0] = 1'b1; clr = 1'b1;
         end else begin
            top = 51; r.exp = exp + 12'd1;
         end
      end else begin
         h = -1;
         for (int i = 0; i <= 50; i++) if (d[i] != 4'd0) h = i;
         if (h < 0) begin
            r.zero = 1'b1; r.exp = 12'd0; clr = 1'b1;
         end else begin
            lz = 50 - h;
            s = (lz < int'(exp)) ? lz : int'(exp);
            top = 50 - s;
            r.exp = exp - 12'(s);
            if (s < lz) r.under = 1'b1;
         end
      end
      if (!clr) begin
         for (int j = 0; j < 25; j++) begin
            idx = top - j;
            r.sig[4*(24-j) +: 4] = (idx >= 0) ? d[idx] : 4'd0;
         end
         r.gr[7:4] = (top - 25 >= 0) ? d[top-25] : 4'd0;
         r.gr[3:0] = (top - 26 >= 0) ? d[top-26] : 4'd0;
         for (int i = 0; i <= top - 27; i++) if (d[i] != 4'd0) r.sticky = 1'b1;
      end
      return r;
   endfunction

   task automatic drive(input logic v, input logic sign, input logic [11:0] e,
                        input logic [207:0] s, input logic [3:0] f, input logic u);
      @(posedge clk);
      #1;
      i_valid = v; i_sign = sign; i_exp = e; i_sig = s; i_flags = f; under_i = u;
      if (v) q.push_back(model(sign, e, s, f, u));
   endtask

   always @(posedge clk) ce_at_edge <= ce;

   always @(negedge clk) begin
      res_t obs, exp_r;
      if (!rst && ce_at_edge && o_valid) begin
         n_total++;
         assert (q.size() != 0) n_pass++;
         else $error("FAIL unexpected_beat: o_valid=1 observed, required no output");
         if (q.size() != 0) begin
            exp_r = q.pop_front();
            obs = {o_sign, o_exp, o_sig, o_gr, o_sticky, o_zero, o_under, o_over, o_flags};
            n_total++;
            assert (obs === exp_r) n_pass++;
            else $error("FAIL beat: observed %h required %h", obs, exp_r);
         end
      end
   end

   initial begin
      logic [207:0] s;
      res_t obs;
      int h;

      #2;
      obs = {o_sign, o_exp, o_sig, o_gr, o_sticky, o_zero, o_under, o_over, o_flags};
      n_total++;
      assert (o_valid === 1'b0) n_pass++;
      else $error("FAIL reset_valid: observed %b required 0", o_valid);
      n_total++;
      assert (obs === res_t'('0)) n_pass++;
      else $error("FAIL reset_outputs: observed %h required 0", obs);
      @(posedge clk); #1 rst = 1'b0;

      // T1 carry
      s = '0; s[4*51 +: 4] = 4'd1;
      drive(1, 0, 12'd100, s, 4'd0, 0);
      // T2 left shift with sticky
      s = '0; s[4*47 +: 4] = 4'd1; s[4*46 +: 4] = 4'd2; s[4*45 +: 4] = 4'd3;
      s[4*44 +: 4] = 4'd4; s[3:0] = 4'd7;
      drive(1, 0, 12'd50, s, 4'd0, 0);
      // T3 exponent clamp
      s = '0; s[4*45 +: 4] = 4'd9; s[4*10 +: 4] = 4'd3;
      drive(1, 0, 12'd2, s, 4'd0, 0);
      // T4 zero, overflow
      drive(1, 1, 12'd500, '0, 4'd0, 0);
      s = '0; s[4*51 +: 4] = 4'd2; s[4*30 +: 4] = 4'd6;
      drive(1, 0, 12'd3071, s, 4'd0, 0);
      // T5 special
      s = '0; s[4*30 +: 4] = 4'd5; s[4*24 +: 4] = 4'd8; s[4*3 +: 4] = 4'd1;
      drive(1, 0, 12'd7, s, 4'b1000, 0);
      // bubble, under_i passthrough, digit>9 as nonzero, full 51-digit shift boundary
      drive(0, 0, 12'd0, '0, 4'd0, 0);
      s = '0; s[4*20 +: 4] = 4'hC;
      drive(1, 1, 12'd40, s, 4'd0, 1);
      s = '0; s[3:0] = 4'd1;
      drive(1, 0, 12'd60, s, 4'd0, 0);

      for (int n = 0; n < 24; n++) begin
         s = '0;
         h = $urandom_range(0, 51);
         for (int i = 0; i < h; i++) s[4*i +: 4] = 4'($urandom_range(0, 15));
         s[4*h +: 4] = 4'($urandom_range(1, 9));
         drive(($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 5) == 0) ? 12'd3071 : 12'($urandom_range(0, 60)),
               s, ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
               1'($urandom_range(0, 1)));
      end

      // T6 ce freeze with beats in flight
      for (int n = 0; n < 3; n++) begin
         s = '0; s[4*(48 - n) +: 4] = 4'(n + 1);
         drive(1, 0, 12'(20 + n), s, 4'd0, 0);
      end
      @(posedge clk); #1;
      ce = 1'b0; i_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 ce = 1'b1;
      repeat (6) drive(0, 0, 12'd0, '0, 4'd0, 0);
      n_total++;
      assert (q.size() == 0) n_pass++;
      else $error("FAIL freeze_drain: observed %0d pending required 0", q.size());

      // T6 reset mid-flight
      for (int n = 0; n < 5; n++) begin
         s = '0; s[4*(40 + n) +: 4] = 4'(n + 2);
         drive(1, 0, 12'd30, s, 4'd0, 0);
      end
      @(posedge clk); #2;
      n_total++;
      assert (o_valid === 1'b1) n_pass++;
      else $error("FAIL pre_reset_valid: observed %b required 1", o_valid);
      rst = 1'b1; i_valid = 1'b0;
      #1;
      n_total++;
      assert (o_valid === 1'b0) n_pass++;
      else $error("FAIL midflight_reset: observed %b required 0", o_valid);
      q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (8) drive(0, 0, 12'd0, '0, 4'd0, 0);

      s = '0; s[4*49 +: 4] = 4'd7;
      drive(1, 1, 12'd10, s, 4'd0, 0);
      repeat (8) drive(0, 0, 12'd0, '0, 4'd0, 0);
      n_total++;
      assert (q.size() == 0) n_pass++;
      else $error("FAIL final_drain: observed %0d pending required 0", q.size());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
